// File: rtl/tick_monitor.sv
// ---------------------------------------------------------------------------
// tick_monitor
//
// Purpose:
//   Measures the spacing of single-cycle tick pulses against a nominal period.
//   The block locks once LOCK_COUNT consecutive in-window periods are seen.
//   While locked, it flags early ticks, late ticks and missing ticks. Faults
//   are sticky: they hold until clear or reset.
//
// Parameters:
//   NOMINAL     expected tick period in CLK cycles
//   TOL         allowed +/- deviation from NOMINAL, in cycles
//   LOCK_COUNT  consecutive in-window periods required to lock
//
// Optional build:
//   TICK_MONITOR_STATS_EN  when defined, adds period_min/period_max outputs.
//                          These track the extremes of every reported period.
//
// Ports:
//   CLK           in   1   sole clock, rising edge
//   reset         in   1   asynchronous, active-low
//   tick_in       in   1   one-cycle tick pulse, synchronous to CLK
//   clear         in   1   synchronous return to IDLE; zeroes faults and counters
//   period_out    out  32  last measured period (cycles)
//   period_valid  out  1   one-cycle pulse when period_out updates
//   locked        out  1   high while locked
//   fault_early   out  1   sticky: a locked period was below NOMINAL-TOL
//   fault_late    out  1   sticky: a locked period exceeded NOMINAL+TOL, or a tick went missing
//   tick_count    out  16  ticks accepted since reset/clear (wraps)
//   period_min    out  32  smallest reported period (STATS_EN only)
//   period_max    out  32  largest reported period  (STATS_EN only)
// ---------------------------------------------------------------------------
module tick_monitor #(
  parameter int unsigned NOMINAL    = 32'd23999001,
  parameter int unsigned TOL        = 32'd16,
  parameter int unsigned LOCK_COUNT = 32'd4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        clear,
  output logic [31:0] period_out,
  output logic        period_valid,
  output logic        locked,
  output logic        fault_early,
  output logic        fault_late,
  output logic [15:0] tick_count
`ifdef TICK_MONITOR_STATS_EN
  ,
  output logic [31:0] period_min,
  output logic [31:0] period_max
`endif
);

  localparam logic [31:0] WIN_LO = 32'(NOMINAL - TOL);
  localparam logic [31:0] WIN_HI = 32'(NOMINAL + TOL);

  // good_cnt only has to reach LOCK_COUNT, so it is sized for that value.
  localparam int GCW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [GCW-1:0] LOCK_TARGET = GCW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic below_win(input logic [31:0] p);
    return (p < WIN_LO);
  endfunction

  function automatic logic above_win(input logic [31:0] p);
    return (p > WIN_HI);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          state;
  logic [31:0]     gap;       // cycles since the last accepted tick
  logic [GCW-1:0]  good_cnt;  // consecutive in-window periods while acquiring

  // -------------------------------------------------------------------------
  // Stage p0: classify the current gap
  // -------------------------------------------------------------------------
  // The gap register already holds the period that a tick in this cycle
  // closes. The same comparison is used for the missing-tick timeout: once
  // gap exceeds the window with no tick, the tick can no longer arrive in time.
  logic           early_p0;
  logic           late_p0;
  logic           in_win_p0;
  logic [GCW-1:0] good_inc_p0;

  always_comb begin
    early_p0    = below_win(gap);
    late_p0     = above_win(gap);
    in_win_p0   = !early_p0 && !late_p0;
    good_inc_p0 = good_cnt + GCW'(1);
  end

  // -------------------------------------------------------------------------
  // Stage p1: registered FSM and outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      gap          <= 32'd0;
      good_cnt     <= '0;
      period_out   <= 32'd0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault_early  <= 1'b0;
      fault_late   <= 1'b0;
      tick_count   <= 16'd0;
`ifdef TICK_MONITOR_STATS_EN
      period_min   <= 32'hFFFF_FFFF;
      period_max   <= 32'd0;
`endif
    end else if (clear) begin
      // clear wins over a coincident tick; period_out keeps its last value
      state        <= IDLE;
      gap          <= 32'd0;
      good_cnt     <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault_early  <= 1'b0;
      fault_late   <= 1'b0;
      tick_count   <= 16'd0;
`ifdef TICK_MONITOR_STATS_EN
      period_min   <= 32'hFFFF_FFFF;
      period_max   <= 32'd0;
`endif
    end else begin
      period_valid <= 1'b0;
      gap          <= tick_in ? 32'd1 : sat_inc(gap);

      if (tick_in) begin
        tick_count <= tick_count + 16'd1;
      end

      // The IDLE tick only starts the measurement; every later tick reports.
      if (tick_in && (state != IDLE)) begin
        period_out   <= gap;
        period_valid <= 1'b1;
`ifdef TICK_MONITOR_STATS_EN
        if (gap < period_min) period_min <= gap;
        if (gap > period_max) period_max <= gap;
`endif
      end

      case (state)
        IDLE: begin
          if (tick_in) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
          end
        end

        ACQUIRE: begin
          if (tick_in) begin
            if (in_win_p0) begin
              good_cnt <= good_inc_p0;
              if (good_inc_p0 == LOCK_TARGET) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
        end

        LOCKED: begin
          // A late tick and a missing tick both show up as gap above the window.
          if (tick_in && early_p0) begin
            state       <= FAULT;
            locked      <= 1'b0;
            fault_early <= 1'b1;
          end else if (late_p0) begin
            state      <= FAULT;
            locked     <= 1'b0;
            fault_late <= 1'b1;
          end
        end

        FAULT: begin
          // Sticky: only clear or reset leaves this state.
          state <= FAULT;
        end

        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_monitor.sv
module tb_tick_monitor;

  logic        CLK;
  logic        reset;
  logic        tick_in;
  logic        clear;
  logic [31:0] period_out;
  logic        period_valid;
  logic        locked;
  logic        fault_early;
  logic        fault_late;
  logic [15:0] tick_count;
`ifdef TICK_MONITOR_STATS_EN
  logic [31:0] period_min;
  logic [31:0] period_max;
`endif

  int total = 0;
  int bad   = 0;

  tick_monitor #(
    .NOMINAL   (100),
    .TOL       (2),
    .LOCK_COUNT(4)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .tick_in     (tick_in),
    .clear       (clear),
    .period_out  (period_out),
    .period_valid(period_valid),
    .locked      (locked),
    .fault_early (fault_early),
    .fault_late  (fault_late),
    .tick_count  (tick_count)
`ifdef TICK_MONITOR_STATS_EN
    ,
    .period_min  (period_min),
    .period_max  (period_max)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called 1ns after the previous tick's edge. Delivers a tick sampled p
  // edges later, so the DUT measures a period of p. Returns 1ns after that edge.
  task automatic send_tick(input int p);
    if (p > 1) cyc(p - 1);
    tick_in = 1'b1;
    cyc(1);
    tick_in = 1'b0;
  endtask

  int per [8] = '{100, 100, 100, 110, 100, 100, 100, 100};

  initial begin
    tick_in = 1'b0;
    clear   = 1'b0;
    reset   = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_period_out", period_out, 0);
    chk("rst_valid", {31'd0, period_valid}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_fault_early", {31'd0, fault_early}, 0);
    chk("rst_fault_late", {31'd0, fault_late}, 0);
    chk("rst_tick_count", {16'd0, tick_count}, 0);
    cyc(2);
    reset = 1'b1;
    cyc(1);

    // Five ticks 100 apart: lock after the fifth
    send_tick(1);
    chk("idle_tick_no_valid", {31'd0, period_valid}, 0);
    chk("idle_tick_count", {16'd0, tick_count}, 1);
    for (int i = 0; i < 3; i++) begin
      send_tick(100);
      chk("acq_valid", {31'd0, period_valid}, 1);
      chk("acq_period", period_out, 100);
      chk("acq_not_locked", {31'd0, locked}, 0);
    end
    send_tick(100);
    chk("lock_period", period_out, 100);
    chk("lock_valid", {31'd0, period_valid}, 1);
    chk("lock_locked", {31'd0, locked}, 1);
    chk("lock_tick_count", {16'd0, tick_count}, 5);
    cyc(1);
    chk("valid_one_cycle", {31'd0, period_valid}, 0);
    chk("still_locked", {31'd0, locked}, 1);

    // Early tick: period 97 (one cycle already spent above)
    send_tick(96);
    chk("early_period", period_out, 97);
    chk("early_fault", {31'd0, fault_early}, 1);
    chk("early_locked_drop", {31'd0, locked}, 0);
    chk("early_no_late", {31'd0, fault_late}, 0);
    send_tick(100);
    chk("fault_period_upd", period_out, 100);
    chk("fault_valid", {31'd0, period_valid}, 1);
    chk("early_sticky", {31'd0, fault_early}, 1);
    chk("fault_not_locked", {31'd0, locked}, 0);
    chk("fault_tick_count", {16'd0, tick_count}, 7);

    // Clear: faults and counters zero, period_out held
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr_fault_early", {31'd0, fault_early}, 0);
    chk("clr_tick_count", {16'd0, tick_count}, 0);
    chk("clr_period_hold", period_out, 100);
    chk("clr_valid", {31'd0, period_valid}, 0);

    // Re-lock, then missing tick
    send_tick(1);
    for (int i = 0; i < 4; i++) send_tick(100);
    chk("relock", {31'd0, locked}, 1);
    cyc(101);
    chk("miss_not_yet", {31'd0, fault_late}, 0);
    chk("miss_still_locked", {31'd0, locked}, 1);
    cyc(3);
    chk("miss_fault_late", {31'd0, fault_late}, 1);
    chk("miss_locked_drop", {31'd0, locked}, 0);
    chk("miss_no_early", {31'd0, fault_early}, 0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr2_fault_late", {31'd0, fault_late}, 0);
    chk("clr2_tick_count", {16'd0, tick_count}, 0);
    chk("clr2_locked", {31'd0, locked}, 0);

    // Out-of-window period during acquisition restarts the count
    send_tick(1);
    for (int i = 0; i < 8; i++) begin
      send_tick(per[i]);
      chk("acq2_period", period_out, 32'(per[i]));
      chk("acq2_locked", {31'd0, locked}, (i == 7) ? 32'd1 : 32'd0);
    end
    chk("acq2_tick_count", {16'd0, tick_count}, 9);

    // Coincident tick and clear: clear wins
    tick_in = 1'b1;
    clear   = 1'b1;
    cyc(1);
    tick_in = 1'b0;
    clear   = 1'b0;
    chk("tc_valid", {31'd0, period_valid}, 0);
    chk("tc_tick_count", {16'd0, tick_count}, 0);
    chk("tc_locked", {31'd0, locked}, 0);
    send_tick(100);
    chk("tc_idle_no_valid", {31'd0, period_valid}, 0);
    chk("tc_idle_count", {16'd0, tick_count}, 1);
    send_tick(100);
    chk("tc_acq_valid", {31'd0, period_valid}, 1);
    chk("tc_acq_period", period_out, 100);

    // Reset mid-gap acts without a clock edge
    cyc(50);
    #3 reset = 1'b0;
    #1;
    chk("arst_period_out", period_out, 0);
    chk("arst_tick_count", {16'd0, tick_count}, 0);
    chk("arst_valid", {31'd0, period_valid}, 0);
    chk("arst_locked", {31'd0, locked}, 0);
    chk("arst_faults", {30'd0, fault_early, fault_late}, 0);
    #2 reset = 1'b1;
    cyc(1);
    send_tick(7);
    chk("post_rst_idle_valid", {31'd0, period_valid}, 0);
    chk("post_rst_count", {16'd0, tick_count}, 1);
    send_tick(100);
    chk("post_rst_period", period_out, 100);
    chk("post_rst_valid", {31'd0, period_valid}, 1);

`ifdef TICK_MONITOR_STATS_EN
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("stats_clr_min", period_min, 32'hFFFF_FFFF);
    chk("stats_clr_max", period_max, 0);
    send_tick(1);
    send_tick(99);
    send_tick(101);
    send_tick(100);
    chk("stats_min", period_min, 99);
    chk("stats_max", period_max, 101);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 Parameter NOMINAL, default 23999001, expected tick period in CLK cycles.
REQ-002 Parameter TOL, default 16, allowed +/- deviation in cycles from NOMINAL.
REQ-003 Parameter LOCK_COUNT, default 4, consecutive in-window periods required to lock.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- CLK  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low.
- tick_in  input  1  one-cycle pulse, synchronous to CLK; each high cycle is one tick event.
- clear  input  1  synchronous: return to IDLE and clear faults and counters.
- period_out  output  32  last measured period, in cycles.
- period_valid  output  1  one-cycle pulse when period_out updates.
- locked  output  1  high while in LOCKED.
- fault_early  output  1  sticky: a locked period was below NOMINAL-TOL.
- fault_late  output  1  sticky: a locked period exceeded NOMINAL+TOL, or a tick went missing.
- tick_count  output  16  ticks accepted since reset or clear; wraps at 65535 -> 0.

Function
REQ-005 Gap counter g (32-bit): on tick g<=1, otherwise g<=g+1, saturating at 0xFFFFFFFF; at a tick the measured period is g.
REQ-006 A period P is in-window iff NOMINAL-TOL <= P <= NOMINAL+TOL; comparisons are unsigned 32-bit.
REQ-007 States SHALL be IDLE, ACQUIRE, LOCKED, FAULT; the state register and all outputs SHALL be registered.
REQ-008 IDLE: a tick SHALL move to ACQUIRE and load g; no period is reported.
REQ-009 ACQUIRE: each tick SHALL report its period; an in-window period increments good_cnt, an out-of-window period zeroes it.
REQ-010 ACQUIRE: when an in-window tick brings good_cnt to LOCK_COUNT, the state SHALL become LOCKED the next cycle.
REQ-011 LOCKED: a tick with P < NOMINAL-TOL SHALL go to FAULT with fault_early=1.
REQ-012 LOCKED: a tick with P > NOMINAL+TOL SHALL go to FAULT with fault_late=1.
REQ-013 LOCKED: if g > NOMINAL+TOL with tick_in low, the block SHALL go to FAULT with fault_late=1 (missing tick).
REQ-014 FAULT is sticky: ticks still update period_out, period_valid and tick_count; the state and fault flags hold until clear or reset.
REQ-015 period_out and the period_valid pulse SHALL appear 1 cycle after the reporting tick (latency 1).
REQ-016 tick_count SHALL increment on every tick in every state, including IDLE.
REQ-017 clear SHALL take priority over a simultaneous tick: the tick is ignored and state becomes IDLE, with g, good_cnt, tick_count and faults zeroed; period_out holds its value.
REQ-018 locked SHALL fall in the same cycle that FAULT is entered.

Reset
REQ-019 Reset low SHALL asynchronously force: state IDLE; g, good_cnt, period_out, tick_count = 0; period_valid, locked, fault_early, fault_late = 0.
REQ-020 Reset asserted mid-measurement SHALL discard the partial period; the first tick after release is treated as an IDLE tick.

Configuration
REQ-021 Macro TICK_MONITOR_STATS_EN present: outputs period_min[31:0] and period_max[31:0] exist.
- Both update on every period_valid.
- Reset and clear set period_min=0xFFFFFFFF and period_max=0.
REQ-022 Macro absent: these ports and their registers SHALL NOT exist; all other behaviour is identical.

Verification (NOMINAL=100, TOL=2, LOCK_COUNT=4)
REQ-023 Five ticks 100 cycles apart -> four period_valid pulses with period_out=100; locked=1 one cycle after the fifth tick; tick_count=5.
REQ-024 Locked, then the next tick arrives 97 cycles after the last -> fault_early=1, locked=0, period_out=97; fault_early stays high through later good ticks.
REQ-025 Locked, then no tick -> fault_late=1 when g reaches 103; clear -> IDLE with all flags and tick_count=0.
REQ-026 ACQUIRE periods 100,100,100,110,100,100,100,100 -> locked only after the eighth tick (good_cnt reset at 110).
REQ-027 tick_in and clear high in the same cycle -> state IDLE, tick_count=0, no period_valid; reset asserted mid-gap -> all outputs 0 immediately, without waiting for a clock edge.
REQ-028 With TICK_MONITOR_STATS_EN, periods 99,101,100 -> period_min=99, period_max=101.
